// File: rtl/idiv_iter.sv
`timescale 1ns/1ps
// idiv_iter: iterative radix-2 restoring integer divider.
// Signed/unsigned, 32- or 64-bit, quotient or remainder, with a flag word
// laid out like the pipelined multiplier's. One restoring step per cycle.
module idiv_iter #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clkEn,
  input  logic         en,
  input  logic [2:0]   op,
  input  logic [W:0]   R,
  input  logic [W:0]   C,
  output logic         busy,
  output logic         rdy,
  output logic [W:0]   Res,
  output logic [5:0]   flg
);

  localparam int H  = W / 2;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} state_t;

  state_t        state_q;
  logic [2:0]    op_q;
  logic [W-1:0]  dvdRaw_q;
  logic [W-1:0]  dvsRaw_q;
  logic [W-1:0]  quo_q;
  logic [W-1:0]  rem_q;
  logic [W-1:0]  dvs_q;
  logic [CW-1:0] cnt_q;
  logic          qneg_q;
  logic          rneg_q;
  logic          dz_q;
  logic          ovf_q;
  logic          busy_q;
  logic          rdy_q;
  logic [W:0]    res_q;
  logic [5:0]    flg_q;

  logic sig;
  logic remSel;
  logic shrt;

  assign sig    = op_q[2];
  assign remSel = op_q[1];
  assign shrt   = op_q[0];

  // Operand bit W carries nothing for this unit.
  logic unusedBits;
  assign unusedBits = ^{R[W], C[W]};

  // Operand preparation: width extension, magnitudes, and early-out detection.
  logic [W-1:0] extA_d, extB_d, absA_d, absB_d, mostNeg_d, load_d;
  logic         negA_d, negB_d, dz_d, ovf_d;

  always_comb begin
    extA_d    = dvdRaw_q;
    extB_d    = dvsRaw_q;
    mostNeg_d = {1'b1, {(W-1){1'b0}}};
    if (shrt) begin
      extA_d    = {{H{sig & dvdRaw_q[H-1]}}, dvdRaw_q[H-1:0]};
      extB_d    = {{H{sig & dvsRaw_q[H-1]}}, dvsRaw_q[H-1:0]};
      mostNeg_d = {{(H+1){1'b1}}, {(H-1){1'b0}}};
    end
    negA_d = sig & extA_d[W-1];
    negB_d = sig & extB_d[W-1];
    absA_d = negA_d ? -extA_d : extA_d;
    absB_d = negB_d ? -extB_d : extB_d;
    dz_d   = (extB_d == '0);
    ovf_d  = sig & (extA_d == mostNeg_d) & (extB_d == '1);
    // Short mode parks the 32-bit magnitude in the top half so MSB-first
    // shifting needs only 32 steps.
    load_d = shrt ? {absA_d[H-1:0], {H{1'b0}}} : absA_d;
  end

  // One restoring step: shift in the next dividend bit and trial-subtract.
  // The (W+1)-bit difference's top bit is the borrow because the shifted
  // partial remainder is always below twice the divisor.
  logic [W:0]   remShift_d, diff_d;
  logic [W-1:0] remStep_d, quoStep_d;

  always_comb begin
    remShift_d = {rem_q, quo_q[W-1]};
    diff_d     = remShift_d - {1'b0, dvs_q};
    remStep_d  = diff_d[W] ? remShift_d[W-1:0] : diff_d[W-1:0];
    quoStep_d  = {quo_q[W-2:0], ~diff_d[W]};
  end

  // Sign fix-up, result selection, width truncation and flag generation.
  logic [W-1:0] qFix_d, rFix_d, sel_d, resW_d;
  logic [5:0]   flgFix_d;

  always_comb begin
    qFix_d   = qneg_q ? -quo_q : quo_q;
    rFix_d   = rneg_q ? -rem_q : rem_q;
    sel_d    = remSel ? rFix_d : qFix_d;
    resW_d   = shrt ? {{H{1'b0}}, sel_d[H-1:0]} : sel_d;
    flgFix_d = {dz_q, ovf_q, 1'b0,
                shrt ? resW_d[H-1] : resW_d[W-1],
                resW_d == '0,
                ~^resW_d[7:0]};
  end

  // Control FSM and datapath registers; everything freezes while clkEn is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      dvdRaw_q <= '0;
      dvsRaw_q <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      rdy_q    <= 1'b0;
      res_q    <= '0;
      flg_q    <= '0;
    end else if (clkEn) begin
      rdy_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (en) begin
            op_q     <= op;
            dvdRaw_q <= R[W-1:0];
            dvsRaw_q <= C[W-1:0];
            busy_q   <= 1'b1;
            state_q  <= PREP;
          end
        end
        PREP: begin
          dvs_q  <= absB_d;
          qneg_q <= negA_d ^ negB_d;
          rneg_q <= negA_d;
          dz_q   <= dz_d;
          ovf_q  <= ovf_d;
          cnt_q  <= shrt ? CW'(H-1) : CW'(W-1);
          if (dz_d) begin
            quo_q   <= '1;
            rem_q   <= extA_d;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            state_q <= FIX;
          end else if (ovf_d) begin
            quo_q   <= extA_d;
            rem_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            state_q <= FIX;
          end else begin
            quo_q   <= load_d;
            rem_q   <= '0;
            state_q <= ITER;
          end
        end
        ITER: begin
          quo_q <= quoStep_d;
          rem_q <= remStep_d;
          if (cnt_q == '0) begin
            state_q <= FIX;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        FIX: begin
          res_q   <= {1'b0, resW_d};
          flg_q   <= flgFix_d;
          rdy_q   <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // A completed result waiting through a stall is only announced once
  // clkEn is back.
  assign rdy  = rdy_q & clkEn;
  assign busy = busy_q;
  assign Res  = res_q;
  assign flg  = flg_q;

endmodule
